fsm_lock: RTL and testbench

FSM_LOCK -- requirements
Module: fsm_lock

---
 rtl/fsm_lock_pkg.sv | 29 ++
 rtl/fsm_lock_timer.sv | 29 ++
 rtl/fsm_lock.sv | 131 +++++++++++++
 tb/tb_fsm_lock.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_lock_pkg.sv
// Shared types and constants for the four-symbol code lock: state encoding,
// code symbols and default parameter values.
package fsm_lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_S1      = 3'd1,
        ST_S2      = 3'd2,
        ST_S3      = 3'd3,
        ST_OPEN    = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_t;

    // Raw symbol values as {X,Y}.
    localparam logic [1:0] SYM_00 = 2'b00;
    localparam logic [1:0] SYM_01 = 2'b01;
    localparam logic [1:0] SYM_10 = 2'b10;
    localparam logic [1:0] SYM_11 = 2'b11;

    // The unlock code, in entry order.
    localparam logic [1:0] CODE_0 = SYM_01;
    localparam logic [1:0] CODE_1 = SYM_00;
    localparam logic [1:0] CODE_2 = SYM_11;
    localparam logic [1:0] CODE_3 = SYM_00;

    localparam int LOCKOUT_CYCLES_DEF = 16;
    localparam int MAX_FAILS_DEF      = 3;

endpackage

// File: rtl/fsm_lock_timer.sv
// Lockout down-counter: load presets CYCLES-1, enable counts down to zero,
// done flags zero.
module fsm_lock_timer #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic done
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= W'(CYCLES - 1);
        end else if (enable && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/fsm_lock.sv
// Code lock: symbols {X,Y} are edge-detected through a two-stage register and
// walked through a code-matching FSM with failure counting and timed lockout.
module fsm_lock
    import fsm_lock_pkg::*;
#(
    parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF,
    parameter int MAX_FAILS      = MAX_FAILS_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               X,
    input  logic                               Y,
    output logic                               unlock,
    output logic [2:0]                         dbg_state,
    output logic [$clog2(MAX_FAILS+1)-1:0]     dbg_fails
);

    localparam int FW = $clog2(MAX_FAILS + 1);

    logic [1:0]    in_q;
    logic [1:0]    prev_q;
    state_t        state;
    logic [FW-1:0] fails;

    logic          evt;
    logic [1:0]    sym;
    state_t        tgt;
    logic          fail;
    logic          lock_trip;
    logic          timer_done;

    assign evt = (in_q != prev_q);
    assign sym = in_q;

    // Normal next state and failure flag; lockout trip overrides the target.
    always_comb begin
        tgt  = state;
        fail = 1'b0;
        case (state)
            ST_IDLE: begin
                if (evt) tgt = (sym == CODE_0) ? ST_S1 : ST_IDLE;
            end
            ST_S1: begin
                if (evt) begin
                    if (sym == CODE_1) begin
                        tgt = ST_S2;
                    end else if (sym == SYM_10 || sym == SYM_11) begin
                        tgt  = ST_IDLE;
                        fail = 1'b1;
                    end
                end
            end
            ST_S2: begin
                if (evt) begin
                    if (sym == CODE_2) begin
                        tgt = ST_S3;
                    end else if (sym == SYM_01) begin
                        tgt  = ST_S1;
                        fail = 1'b1;
                    end else if (sym == SYM_10) begin
                        tgt  = ST_IDLE;
                        fail = 1'b1;
                    end
                end
            end
            ST_S3: begin
                if (evt) begin
                    if (sym == CODE_3) begin
                        tgt = ST_OPEN;
                    end else if (sym == SYM_01) begin
                        tgt  = ST_S1;
                        fail = 1'b1;
                    end else if (sym == SYM_10) begin
                        tgt  = ST_IDLE;
                        fail = 1'b1;
                    end
                end
            end
            ST_OPEN: begin
                if (evt) tgt = (sym == SYM_01) ? ST_S1 : ST_IDLE;
            end
            ST_LOCKOUT: begin
                tgt = timer_done ? ST_IDLE : ST_LOCKOUT;
            end
            default: tgt = ST_IDLE;
        endcase
    end

    assign lock_trip = fail && (fails == FW'(MAX_FAILS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q   <= SYM_00;
            prev_q <= SYM_00;
            state  <= ST_IDLE;
            fails  <= '0;
            unlock <= 1'b0;
        end else begin
            // The input pipeline keeps running in lockout so exit sees no stale edge.
            in_q   <= {X, Y};
            prev_q <= in_q;
            if (lock_trip) begin
                state  <= ST_LOCKOUT;
                fails  <= '0;
                unlock <= 1'b0;
            end else begin
                state  <= tgt;
                unlock <= (tgt == ST_OPEN);
                if (tgt == ST_OPEN) begin
                    fails <= '0;
                end else if (fail) begin
                    fails <= fails + FW'(1);
                end
            end
        end
    end

    fsm_lock_timer #(
        .CYCLES (LOCKOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (lock_trip),
        .enable (state == ST_LOCKOUT),
        .done   (timer_done)
    );

    assign dbg_state = state;
    assign dbg_fails = fails;

endmodule

// File: tb/tb_fsm_lock.sv
// Directed and randomized checks of fsm_lock against a cycle-level
// behavioural model plus hand-computed expectations.
module tb_fsm_lock;
    import fsm_lock_pkg::*;

    localparam int LC = 16;
    localparam int MF = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x = 1'b0;
    logic       y = 1'b0;
    logic       unlock;
    logic [2:0] dbg_state;
    logic [1:0] dbg_fails;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    logic [1:0] m_in = 2'b00;
    logic [1:0] m_prev = 2'b00;
    state_t     m_state = ST_IDLE;
    int         m_fails = 0;
    int         m_timer = 0;
    logic       m_unlock = 1'b0;
    logic [1:0] code [4] = '{2'b01, 2'b00, 2'b11, 2'b00};

    always #5 clk = ~clk;

    fsm_lock #(
        .LOCKOUT_CYCLES (LC),
        .MAX_FAILS      (MF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .X         (x),
        .Y         (y),
        .unlock    (unlock),
        .dbg_state (dbg_state),
        .dbg_fails (dbg_fails)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic state_t progress_state(input int p);
        case (p)
            1:       return ST_S1;
            2:       return ST_S2;
            3:       return ST_S3;
            default: return ST_OPEN;
        endcase
    endfunction

    // One rising edge of the reference model; sym is what the DUT samples.
    task automatic mdl_edge(input logic r, input logic [1:0] sym);
        int p;
        logic [1:0] s;
        if (r) begin
            m_in = 2'b00; m_prev = 2'b00; m_state = ST_IDLE;
            m_fails = 0; m_timer = 0; m_unlock = 1'b0;
            return;
        end
        s = m_in;
        if (m_state == ST_LOCKOUT) begin
            if (m_timer == 0) m_state = ST_IDLE;
            else m_timer--;
        end else if (m_in != m_prev) begin
            if (m_state == ST_IDLE || m_state == ST_OPEN) begin
                m_state = (s == 2'b01) ? ST_S1 : ST_IDLE;
            end else begin
                p = (m_state == ST_S1) ? 1 : (m_state == ST_S2) ? 2 : 3;
                if (s == code[p]) begin
                    m_state = progress_state(p + 1);
                    if (m_state == ST_OPEN) m_fails = 0;
                end else begin
                    m_fails++;
                    if (m_fails == MF) begin
                        m_fails = 0;
                        m_timer = LC - 1;
                        m_state = ST_LOCKOUT;
                    end else begin
                        m_state = (s == 2'b01) ? ST_S1 : ST_IDLE;
                    end
                end
            end
        end
        m_prev   = m_in;
        m_in     = sym;
        m_unlock = (m_state == ST_OPEN);
    endtask

    task automatic tick(input logic [1:0] sym);
        x = sym[1];
        y = sym[0];
        @(posedge clk);
        mdl_edge(rst, sym);
        #1;
        check("model_unlock", unlock, m_unlock);
        check("model_state", dbg_state, m_state);
        check("model_fails", dbg_fails, m_fails);
    endtask

    task automatic apply(input logic [1:0] sym, input int n);
        repeat (n) tick(sym);
    endtask

    task automatic enter_code(input int hold);
        apply(2'b01, hold);
        apply(2'b00, hold);
        apply(2'b11, hold);
        apply(2'b00, hold);
    endtask

    initial begin
        logic [1:0] rs;
        int         rn;

        // reset state
        rst = 1'b1;
        tick(2'b00);
        rst = 1'b0;
        check("reset_unlock", unlock, 0);
        check("reset_state", dbg_state, ST_IDLE);
        check("reset_fails", dbg_fails, 0);

        // correct code, latency of the final symbol
        apply(2'b01, 8);
        apply(2'b00, 4);
        apply(2'b11, 4);
        tick(2'b00);
        check("open_lat1", unlock, 0);
        tick(2'b00);
        check("open_lat2", unlock, 1);
        apply(2'b00, 2);
        check("open_hold", unlock, 1);
        check("open_state", dbg_state, ST_OPEN);

        // re-lock with 01, then reopen
        tick(2'b01);
        check("relock_lat1", unlock, 1);
        tick(2'b01);
        check("relock_lat2", unlock, 0);
        check("relock_state", dbg_state, ST_S1);
        apply(2'b01, 2);
        apply(2'b00, 4);
        apply(2'b11, 4);
        apply(2'b00, 4);
        check("reopen", unlock, 1);

        // three failures -> lockout
        apply(2'b01, 4);
        apply(2'b10, 4);
        check("fail_cnt1", dbg_fails, 1);
        apply(2'b01, 4);
        apply(2'b10, 4);
        check("fail_cnt2", dbg_fails, 2);
        check("fail_state", dbg_state, ST_IDLE);
        apply(2'b01, 4);
        tick(2'b10);
        check("pre_lockout", dbg_state, ST_S1);
        tick(2'b10);
        check("lockout_entry", dbg_state, ST_LOCKOUT);
        check("lockout_fails", dbg_fails, 0);
        apply(2'b10, 2);
        enter_code(2);
        check("lockout_ignores_code", unlock, 0);
        check("lockout_state_mid", dbg_state, ST_LOCKOUT);
        apply(2'b00, 5);
        check("lockout_last_cycle", dbg_state, ST_LOCKOUT);
        tick(2'b00);
        check("lockout_exit", dbg_state, ST_IDLE);

        // after lockout: one failure, then the code clears the counter
        apply(2'b01, 3);
        apply(2'b10, 3);
        check("post_lock_fail", dbg_fails, 1);
        enter_code(3);
        check("post_lock_open", unlock, 1);
        check("post_lock_fails", dbg_fails, 0);

        // reset while open
        rst = 1'b1;
        tick(2'b00);
        rst = 1'b0;
        check("rst_open_unlock", unlock, 0);
        check("rst_open_state", dbg_state, ST_IDLE);

        // reset mid-lockout
        repeat (3) begin
            apply(2'b01, 2);
            apply(2'b10, 2);
        end
        apply(2'b10, 3);
        check("lockout_again", dbg_state, ST_LOCKOUT);
        rst = 1'b1;
        tick(2'b10);
        rst = 1'b0;
        check("rst_lockout_state", dbg_state, ST_IDLE);

        // 01 held through reset release creates exactly one event
        rst = 1'b1;
        apply(2'b01, 2);
        rst = 1'b0;
        tick(2'b01);
        check("held01_first", dbg_state, ST_IDLE);
        tick(2'b01);
        check("held01_event", dbg_state, ST_S1);
        apply(2'b01, 3);
        check("held01_hold", dbg_state, ST_S1);

        // one-cycle transit symbol counts as an event
        tick(2'b11);
        apply(2'b00, 3);
        check("skew_state", dbg_state, ST_IDLE);
        check("skew_fails", dbg_fails, 1);

        // randomized run against the model
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                tick(2'($urandom_range(0, 3)));
                rst = 1'b0;
            end else if ($urandom_range(0, 9) < 3) begin
                enter_code($urandom_range(1, 3));
            end else begin
                rs = 2'($urandom_range(0, 3));
                rn = $urandom_range(1, 3);
                apply(rs, rn);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
